imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the pipelined core fetches from through PCF/InstrF.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes those words sequentially into instruction memory from word address 0, then validates an XOR checksum.
- Holds the core in reset until a load completes successfully; only then is the core released to fetch.

---
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles a length-prefixed byte stream
// into little-endian words, writes them from address 0, verifies an XOR checksum.
//
// state | meaning
// LEN0  | waiting for low byte of word count
// LEN1  | waiting for high byte of word count
// DATA  | receiving payload bytes, writing one word per 4 bytes
// CHK   | waiting for checksum byte
// DONE  | load good, core released
// ERR   | load aborted, core held in reset
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_err,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;

  localparam logic [16:0]         CAPACITY = 17'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IDX_ONE  = (ADDR_WIDTH+1)'(1);

  state_t              state;
  logic [7:0]          len_lo;
  logic [15:0]         len;
  logic [31:0]         asm_word;
  logic [7:0]          chk;
  logic [1:0]          byte_cnt;
  logic [ADDR_WIDTH:0] word_idx;

  logic        xfer;
  logic [16:0] len_rx;
  logic [15:0] idx_next;
  logic [31:0] asm_next;

  assign rx_ready = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHK);
  assign xfer     = rx_valid && rx_ready;
  assign len_rx   = {1'b0, rx_data, len_lo};
  assign idx_next = 16'(word_idx) + 16'd1;
  // first byte of a word ends up in [7:0] after four right-shifts
  assign asm_next = {rx_data, asm_word[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LEN0;
      len_lo       <= 8'h00;
      len          <= 16'h0000;
      asm_word     <= 32'h0;
      chk          <= 8'h00;
      byte_cnt     <= 2'd0;
      word_idx     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= 16'h0000;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LEN0: if (xfer) begin
          len_lo <= rx_data;
          state  <= LEN1;
        end
        LEN1: if (xfer) begin
          len <= len_rx[15:0];
          if (len_rx > CAPACITY) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else if (len_rx == 17'd0) begin
            state <= CHK;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (xfer) begin
          asm_word <= asm_next;
          chk      <= chk ^ rx_data;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            imem_we      <= 1'b1;
            imem_addr    <= word_idx[ADDR_WIDTH-1:0];
            imem_wdata   <= asm_next;
            word_idx     <= word_idx + IDX_ONE;
            words_loaded <= words_loaded + 16'd1;
            if (idx_next == len) state <= CHK;
          end
        end
        CHK: if (xfer) begin
          if (rx_data == chk) begin
            state     <= DONE;
            load_done <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state    <= ERR;
            load_err <= 1'b1;
          end
        end
        DONE, ERR: if (start) begin
          state        <= LEN0;
          len_lo       <= 8'h00;
          len          <= 16'h0000;
          asm_word     <= 32'h0;
          chk          <= 8'h00;
          byte_cnt     <= 2'd0;
          word_idx     <= '0;
          cpu_reset    <= 1'b1;
          load_done    <= 1'b0;
          load_err     <= 1'b0;
          words_loaded <= 16'h0000;
        end
        default: state <= LEN0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares each imem_we strobe.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  imem_loader #(.ADDR_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          bad++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Called just after a negedge; returns #1 after the negedge following the transfer.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (rx_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: got rx_ready %b expected 1 for byte %h", rx_ready, b);
    end
    @(negedge clk); #1;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic expect_wr(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_two_word(input logic [7:0] chk_byte, input int gap);
    logic [7:0] bytes [11];
    bytes = '{8'h02, 8'h00, 8'h05, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h80, 8'hE2, 8'h35};
    bytes[10] = chk_byte;
    expect_wr(6'd0, 32'hE3A00005);
    expect_wr(6'd1, 32'hE2801001);
    for (int i = 0; i < 11; i++) send(bytes[i], gap);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic cpur, input logic rdy, input logic [15:0] wl);
    check({tag, "_load_done"}, 32'(load_done), 32'(done));
    check({tag, "_load_err"}, 32'(load_err), 32'(err));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cpur));
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'(rdy));
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(wl));
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  x;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    check("rst_imem_we", 32'(imem_we), 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check_status("rst", 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);

    // two-word load, back-to-back bytes
    send_two_word(8'h35, 0);
    check_status("two_word", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    repeat (3) @(negedge clk);
    #1 check("done_hold_rx_ready", 32'(rx_ready), 0);

    // restart clears status
    pulse_start();
    check_status("restart", 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);

    // same frame with 3-cycle bubbles
    send_two_word(8'h35, 3);
    check_status("bubbles", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);

    // bad checksum
    pulse_start();
    send_two_word(8'h34, 0);
    check_status("bad_chk", 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);

    // zero-length frame
    pulse_start();
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    check_status("zero_len", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

    // over-length frame aborts right after LEN_HI
    pulse_start();
    send(8'h41, 0); send(8'h00, 0);
    check_status("over_len", 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);

    // exactly full memory
    pulse_start();
    send(8'h40, 0); send(8'h00, 0);
    x = 8'h00;
    for (int k = 0; k < 64; k++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        b = 8'((k * 4 + j) * 7 + 3);
        w[j*8 +: 8] = b;
        x = x ^ b;
      end
      expect_wr(6'(k), w);
      for (int j = 0; j < 4; j++) send(w[j*8 +: 8], 0);
    end
    send(x, 0);
    check_status("full_mem", 1'b1, 1'b0, 1'b0, 1'b0, 16'd64);

    // reset mid-frame after 6 payload bytes: only word 0 completes
    pulse_start();
    expect_wr(6'd0, 32'hE3A00005);
    send(8'h02, 0); send(8'h00, 0);
    send(8'h05, 0); send(8'h00, 0); send(8'hA0, 0); send(8'hE3, 0);
    send(8'h01, 0); send(8'h10, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    check("midrst_imem_we", 32'(imem_we), 0);
    check("midrst_imem_addr", 32'(imem_addr), 0);
    check("midrst_imem_wdata", imem_wdata, 0);
    check_status("midrst", 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    send_two_word(8'h35, 0);
    check_status("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);

    // restart with a one-word frame
    pulse_start();
    expect_wr(6'd0, 32'h12345678);
    send(8'h01, 0); send(8'h00, 0);
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
    send(8'h08, 0);
    check_status("one_word", 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);

    // start during DATA is ignored
    pulse_start();
    expect_wr(6'd0, 32'hE3A00005);
    expect_wr(6'd1, 32'hE2801001);
    send(8'h02, 0); send(8'h00, 0); send(8'h05, 0); send(8'h00, 0);
    pulse_start();
    check("start_in_data_words", 32'(words_loaded), 0);
    send(8'hA0, 0); send(8'hE3, 0); send(8'h01, 0); send(8'h10, 0);
    send(8'h80, 0); send(8'hE2, 0); send(8'h35, 0);
    check_status("start_in_data", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
